// File: rtl/execute_stage.sv
// Execute stage: decode/execute register, 16-bit ALU, srcB routing, result
// mux, and execute/memory register. Two-cycle latency, no stall or flush.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wbs/wme/mm/wm/ni_in   control bits, carried to *_out two edges later
//   ALUop_in              ALU operation code (consumed here)
//   am_in                 srcB routing: 0 = result path, 1 = store data
//   sel_in                result mux: 0 = ALU result, 1 = routed srcB
//   srcA_in, srcB_in      16-bit operands
//   wbs/wme/mm/wm/ni_out  registered control bits for the memory stage
//   ALUresult_out         registered mux result
//   memData_out           registered store data
//   flagN, flagZ          combinational flags of the current ALU result
module execute_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_in,
    input  logic        wme_in,
    input  logic        mm_in,
    input  logic        wm_in,
    input  logic        ni_in,
    input  logic [2:0]  ALUop_in,
    input  logic        am_in,
    input  logic        sel_in,
    input  logic [15:0] srcA_in,
    input  logic [15:0] srcB_in,
    output logic        wbs_out,
    output logic        wme_out,
    output logic        mm_out,
    output logic        wm_out,
    output logic        ni_out,
    output logic [15:0] ALUresult_out,
    output logic [15:0] memData_out,
    output logic        flagN,
    output logic        flagZ
);

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [2:0]  op;
        logic        am;
        logic        sel;
        logic [15:0] a;
        logic [15:0] b;
    } id_ex_t;

    typedef struct packed {
        logic [4:0]  ctrl;
        logic [15:0] res;
        logic [15:0] data;
    } ex_mem_t;

    id_ex_t      ie_q;
    ex_mem_t     em_q;
    logic [15:0] alu;
    logic [15:0] route0;
    logic [15:0] store;
    logic [15:0] mux;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_q <= '0;
        end else begin
            ie_q.ctrl <= {wbs_in, wme_in, mm_in, wm_in, ni_in};
            ie_q.op   <= ALUop_in;
            ie_q.am   <= am_in;
            ie_q.sel  <= sel_in;
            ie_q.a    <= srcA_in;
            ie_q.b    <= srcB_in;
        end
    end

    // Products and sums keep only the low 16 bits.
    always_comb begin
        alu = '0;
        unique case (ie_q.op)
            3'b000: alu = ie_q.b;
            3'b001: alu = ie_q.a + ie_q.b;
            3'b010: alu = ie_q.a - ie_q.b;
            3'b011: alu = ie_q.a * ie_q.b;
            3'b100: alu = ie_q.a << ie_q.b[3:0];
            3'b101: alu = ie_q.a >> ie_q.b[3:0];
            3'b110: alu = ie_q.a & ie_q.b;
            3'b111: alu = ie_q.a | ie_q.b;
            default: alu = '0;
        endcase
    end

    assign flagN = alu[15];
    assign flagZ = (alu == 16'h0000);

    // srcB goes either to the result path or to the store-data path.
    assign route0 = ie_q.am ? 16'h0000 : ie_q.b;
    assign store  = ie_q.am ? ie_q.b : 16'h0000;
    assign mux    = ie_q.sel ? route0 : alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_q <= '0;
        end else begin
            em_q.ctrl <= ie_q.ctrl;
            em_q.res  <= mux;
            em_q.data <= store;
        end
    end

    assign {wbs_out, wme_out, mm_out, wm_out, ni_out} = em_q.ctrl;
    assign ALUresult_out = em_q.res;
    assign memData_out   = em_q.data;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors with hand-computed
// flags (one edge later) and registered outputs (two edges later).
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbs_in, wme_in, mm_in, wm_in, ni_in;
    logic [2:0]  ALUop_in;
    logic        am_in, sel_in;
    logic [15:0] srcA_in, srcB_in;
    logic        wbs_out, wme_out, mm_out, wm_out, ni_out;
    logic [15:0] ALUresult_out, memData_out;
    logic        flagN, flagZ;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in),
        .wm_in(wm_in), .ni_in(ni_in),
        .ALUop_in(ALUop_in), .am_in(am_in), .sel_in(sel_in),
        .srcA_in(srcA_in), .srcB_in(srcB_in),
        .wbs_out(wbs_out), .wme_out(wme_out), .mm_out(mm_out),
        .wm_out(wm_out), .ni_out(ni_out),
        .ALUresult_out(ALUresult_out), .memData_out(memData_out),
        .flagN(flagN), .flagZ(flagZ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ctrl;
        logic [2:0]  op;
        logic        am;
        logic        sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] mem;
        logic        n;
        logic        z;
    } vec_t;

    typedef struct {
        logic [4:0]  ctrl;
        logic [15:0] res;
        logic [15:0] mem;
    } out_t;

    vec_t vecs[13];
    logic [1:0] flag_q[$];
    out_t       out_q[$];

    int n_vec = 0;
    int n_err = 0;
    logic issue = 1'b0;
    logic v1 = 1'b0;
    logic v2 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {wbs_in, wme_in, mm_in, wm_in, ni_in} = v.ctrl;
        ALUop_in = v.op;
        am_in    = v.am;
        sel_in   = v.sel;
        srcA_in  = v.a;
        srcB_in  = v.b;
    endtask

    // Monitor: tracks which cycles carry a scoreboarded vector.
    always @(posedge clk) begin
        v2 = v1;
        v1 = issue;
        issue = 1'b0;
        #1;
        if (v1) begin
            if (flag_q.size() == 0) chk("flag_q_underflow", 1, 0);
            else chk("flags_NZ", {30'd0, flagN, flagZ}, {30'd0, flag_q.pop_front()});
        end
        if (v2) begin
            if (out_q.size() == 0) chk("out_q_underflow", 1, 0);
            else begin
                out_t e;
                e = out_q.pop_front();
                chk("ALUresult_out", {16'd0, ALUresult_out}, {16'd0, e.res});
                chk("memData_out", {16'd0, memData_out}, {16'd0, e.mem});
                chk("ctrl_out", {27'd0, wbs_out, wme_out, mm_out, wm_out, ni_out},
                    {27'd0, e.ctrl});
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_res"}, {16'd0, ALUresult_out}, 32'd0);
        chk({tag, "_mem"}, {16'd0, memData_out}, 32'd0);
        chk({tag, "_ctrl"}, {27'd0, wbs_out, wme_out, mm_out, wm_out, ni_out}, 32'd0);
        chk({tag, "_flags"}, {30'd0, flagN, flagZ}, 32'd1);
    endtask

    initial begin
        vec_t zero_v;
        //          ctrl      op    am    sel   a         b         res       mem       n     z
        vecs[0]  = '{5'b11111, 3'd1, 1'b0, 1'b0, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{5'b01011, 3'd3, 1'b1, 1'b0, 16'h0050, 16'h0007, 16'h0230, 16'h0007, 1'b0, 1'b0};
        vecs[2]  = '{5'b10101, 3'd4, 1'b0, 1'b0, 16'h0001, 16'h001F, 16'h8000, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{5'b00110, 3'd0, 1'b0, 1'b1, 16'hFFFF, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{5'b11000, 3'd2, 1'b0, 1'b0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[5]  = '{5'b00011, 3'd2, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{5'b10000, 3'd5, 1'b0, 1'b0, 16'h8000, 16'h0013, 16'h1000, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{5'b01000, 3'd6, 1'b1, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h3C3C, 1'b0, 1'b0};
        vecs[8]  = '{5'b00100, 3'd7, 1'b1, 1'b1, 16'hF000, 16'h000F, 16'h0000, 16'h000F, 1'b1, 1'b0};
        vecs[9]  = '{5'b00001, 3'd0, 1'b0, 1'b0, 16'h1234, 16'h8001, 16'h8001, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{5'b00010, 3'd3, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[11] = '{5'b10010, 3'd1, 1'b0, 1'b0, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000, 1'b0, 1'b0};
        vecs[12] = '{5'b01101, 3'd4, 1'b0, 1'b0, 16'h0003, 16'hFFF4, 16'h0030, 16'h0000, 1'b0, 1'b0};
        zero_v = '{5'b0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1};

        rst_n = 1'b0;
        drive(zero_v);
        #3;
        chk_reset_state("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream of all vectors.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            flag_q.push_back({vecs[i].n, vecs[i].z});
            out_q.push_back('{vecs[i].ctrl, vecs[i].res, vecs[i].mem});
            issue = 1'b1;
        end
        @(negedge clk);
        drive(zero_v);

        for (int k = 0; k < 10; k++) begin
            if (flag_q.size() == 0 && out_q.size() == 0) break;
            @(posedge clk);
        end
        #2;
        chk("drain_timeout", flag_q.size() + out_q.size(), 0);

        // Put data in both registers, then reset between edges.
        @(negedge clk);
        drive(vecs[0]);
        @(negedge clk);
        drive(vecs[2]);
        @(posedge clk);
        #2;
        chk("inflight_res", {16'd0, ALUresult_out}, 32'h0005);
        chk("inflight_flagN", {31'd0, flagN}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state("reset_async");
        @(posedge clk);
        #1;
        chk_reset_state("reset_held");
        @(negedge clk);
        drive(zero_v);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("after_release_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
